// File: rtl/reg_write_arbiter_pkg.sv
// Shared types and default sizing for the round-robin register write arbiter.
package reg_write_arbiter_pkg;

    localparam int N_REQ_DEF   = 4;
    localparam int WIDTH_DEF   = 4;
    localparam int TIMEOUT_DEF = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        WRITE   = 2'b01,
        RELEASE = 2'b10
    } arb_state_t;

    function automatic int nextIndex(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Requester-side bus of the arbiter; timeout_err exists only with REG_WRITE_ARBITER_TIMEOUT_EN.
interface reg_write_arbiter_if
    import reg_write_arbiter_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int WIDTH = WIDTH_DEF
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] data_in;
    logic [N_REQ-1:0]       gnt;
    logic [IDX_W-1:0]       owner;
    logic [WIDTH-1:0]       y;
    logic                   y_valid;
    logic                   wr_done;
    logic                   busy;
`ifdef REG_WRITE_ARBITER_TIMEOUT_EN
    logic                   timeout_err;

    modport master (output req, data_in,
                    input  gnt, owner, y, y_valid, wr_done, busy, timeout_err);
    modport slave  (input  req, data_in,
                    output gnt, owner, y, y_valid, wr_done, busy, timeout_err);
`else
    modport master (output req, data_in,
                    input  gnt, owner, y, y_valid, wr_done, busy);
    modport slave  (input  req, data_in,
                    output gnt, owner, y, y_valid, wr_done, busy);
`endif

endinterface

// File: rtl/reg_write_arbiter_rr_pick.sv
// Combinational round-robin pick: first asserted request at or above rr_ptr, wrapping.
module rr_pick
    import reg_write_arbiter_pkg::*;
#(
    parameter  int N_REQ = N_REQ_DEF,
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] rr_ptr_i,
    output logic [IDX_W-1:0] winner_o,
    output logic             any_req_o
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        winner_o  = '0;
        any_req_o = 1'b0;
        idx       = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = IDX_W'((int'(rr_ptr_i) + k) % N_REQ);
            if (!any_req_o && req_i[idx]) begin
                winner_o  = idx;
                any_req_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing one result register among N_REQ four-phase requesters.
// Define REG_WRITE_ARBITER_TIMEOUT_EN to abort a RELEASE that outlasts TIMEOUT cycles.
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int WIDTH = WIDTH_DEF
`ifdef REG_WRITE_ARBITER_TIMEOUT_EN
    ,
    parameter int TIMEOUT = TIMEOUT_DEF
`endif
) (
    input logic               clk,
    input logic               reset,
    reg_write_arbiter_if.slave bus
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_t       state_q;
    logic [N_REQ-1:0] gnt_q;
    logic [IDX_W-1:0] owner_q;
    logic [IDX_W-1:0] rr_ptr_q;
    logic [IDX_W-1:0] rr_ptr_d;
    logic [WIDTH-1:0] y_q;
    logic             y_valid_q;
    logic             wr_done_q;
    logic             busy_q;
    logic [IDX_W-1:0] winner;
    logic             anyReq;
    logic [WIDTH-1:0] dataArr [N_REQ];

`ifdef REG_WRITE_ARBITER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q;
    logic             timeout_err_q;
`endif

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign dataArr[g] = bus.data_in[g*WIDTH +: WIDTH];
    end

    // The pointer moves past the owner so it becomes lowest priority next round.
    assign rr_ptr_d = IDX_W'(nextIndex(int'(owner_q), N_REQ));

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req_i    (bus.req),
        .rr_ptr_i (rr_ptr_q),
        .winner_o (winner),
        .any_req_o(anyReq)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            owner_q   <= '0;
            rr_ptr_q  <= '0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
            wr_done_q <= 1'b0;
            busy_q    <= 1'b0;
`ifdef REG_WRITE_ARBITER_TIMEOUT_EN
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            wr_done_q <= 1'b0;
`ifdef REG_WRITE_ARBITER_TIMEOUT_EN
            timeout_err_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (anyReq) begin
                        state_q <= WRITE;
                        gnt_q   <= N_REQ'(1) << winner;
                        owner_q <= winner;
                        busy_q  <= 1'b1;
                    end
                end
                WRITE: begin
                    y_q       <= dataArr[owner_q];
                    y_valid_q <= 1'b1;
                    wr_done_q <= 1'b1;
                    rr_ptr_q  <= rr_ptr_d;
                    state_q   <= RELEASE;
`ifdef REG_WRITE_ARBITER_TIMEOUT_EN
                    cnt_q     <= '0;
`endif
                end
                RELEASE: begin
                    if (!bus.req[owner_q]) begin
                        state_q <= IDLE;
                        gnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end
`ifdef REG_WRITE_ARBITER_TIMEOUT_EN
                    else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        state_q       <= IDLE;
                        gnt_q         <= '0;
                        busy_q        <= 1'b0;
                        timeout_err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
`endif
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.owner   = owner_q;
    assign bus.y       = y_q;
    assign bus.y_valid = y_valid_q;
    assign bus.wr_done = wr_done_q;
    assign bus.busy    = busy_q;
`ifdef REG_WRITE_ARBITER_TIMEOUT_EN
    assign bus.timeout_err = timeout_err_q;
`endif

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: vector table, handshake sequences, random vs model.
module tb_reg_write_arbiter;
    import reg_write_arbiter_pkg::*;

    localparam int N = 4;
    localparam int W = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    reg_write_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

    reg_write_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int failures = 0;
    int grantLog[$];
    int yLog[$];

    typedef struct {
        logic [N-1:0]   reqVec;
        logic [N*W-1:0] data;
        bit             dropInWrite;
        int             expOwner;
        logic [W-1:0]   expY;
    } vec_t;

    vec_t vecs [8];

    // Reference model state: grant age counts edges since the grant was issued.
    int         mPtr, mOwner, mAge;
    bit         mActive, mValid, mWrDone;
    logic [W-1:0] mY;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [N-1:0] r, input logic [N*W-1:0] d);
        bus.req     = r;
        bus.data_in = d;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic doReset();
        reset = 1'b1;
        applyStimulus('0, '0);
        tick();
        reset = 1'b0;
    endtask

    task automatic runVector(input vec_t v, input int idx);
        applyStimulus(v.reqVec, v.data);
        tick();
        checkOutput($sformatf("v%0d_gnt", idx), 32'(bus.gnt), 32'(1 << v.expOwner));
        checkOutput($sformatf("v%0d_owner", idx), 32'(bus.owner), 32'(v.expOwner));
        checkOutput($sformatf("v%0d_busy", idx), 32'(bus.busy), 32'd1);
        checkOutput($sformatf("v%0d_wrdone_early", idx), 32'(bus.wr_done), 32'd0);
        if (v.dropInWrite) bus.req = '0;
        tick();
        checkOutput($sformatf("v%0d_wrdone", idx), 32'(bus.wr_done), 32'd1);
        checkOutput($sformatf("v%0d_y", idx), 32'(bus.y), 32'(v.expY));
        checkOutput($sformatf("v%0d_yvalid", idx), 32'(bus.y_valid), 32'd1);
        checkOutput($sformatf("v%0d_gnt_write", idx), 32'(bus.gnt), 32'(1 << v.expOwner));
        if (!v.dropInWrite) begin
            tick();
            checkOutput($sformatf("v%0d_gnt_hold", idx), 32'(bus.gnt), 32'(1 << v.expOwner));
            checkOutput($sformatf("v%0d_wrdone_pulse", idx), 32'(bus.wr_done), 32'd0);
            bus.req = '0;
        end
        tick();
        checkOutput($sformatf("v%0d_gnt_off", idx), 32'(bus.gnt), 32'd0);
        checkOutput($sformatf("v%0d_busy_off", idx), 32'(bus.busy), 32'd0);
        checkOutput($sformatf("v%0d_y_hold", idx), 32'(bus.y), 32'(v.expY));
        checkOutput($sformatf("v%0d_owner_hold", idx), 32'(bus.owner), 32'(v.expOwner));
    endtask

    task automatic serveAndLog(input logic [N-1:0] startReq, input logic [N*W-1:0] d,
                               input bit reraise, input int wantGrants);
        logic [N-1:0] prevGnt;
        int cyc;
        prevGnt = '0;
        cyc = 0;
        grantLog.delete();
        yLog.delete();
        applyStimulus(startReq, d);
        while ((grantLog.size() < wantGrants || yLog.size() < wantGrants) && cyc < 80) begin
            tick();
            cyc++;
            if (bus.gnt != '0 && prevGnt == '0) grantLog.push_back(int'(bus.owner));
            if (bus.wr_done) yLog.push_back(int'(bus.y));
            prevGnt = bus.gnt;
            if (bus.wr_done) bus.req = (reraise ? startReq : bus.req) & ~bus.gnt;
            else if (reraise) bus.req = startReq;
        end
        bus.req = '0;
        repeat (4) tick();
    endtask

    task automatic checkLogs(input string tag, input int expG[$], input int expYv[$]);
        checkOutput({tag, "_grant_count"}, 32'(grantLog.size()), 32'(expG.size()));
        checkOutput({tag, "_y_count"}, 32'(yLog.size()), 32'(expYv.size()));
        for (int i = 0; i < expG.size(); i++)
            if (i < grantLog.size()) checkOutput($sformatf("%s_grant%0d", tag, i), 32'(grantLog[i]), 32'(expG[i]));
        for (int i = 0; i < expYv.size(); i++)
            if (i < yLog.size()) checkOutput($sformatf("%s_y%0d", tag, i), 32'(yLog[i]), 32'(expYv[i]));
    endtask

    task automatic modelReset();
        mPtr = 0; mOwner = 0; mAge = 0;
        mActive = 0; mValid = 0; mWrDone = 0; mY = '0;
    endtask

    task automatic modelStep(input logic [N-1:0] r, input logic [N*W-1:0] d);
        int c;
        if (mActive) begin
            mAge++;
            if (mAge == 2) begin
                mY = d[mOwner*W +: W];
                mValid = 1;
                mWrDone = 1;
                mPtr = (mOwner + 1) % N;
            end else begin
                mWrDone = 0;
                if (!r[mOwner]) mActive = 0;
            end
        end else begin
            mWrDone = 0;
            for (int k = 0; k < N; k++) begin
                c = (mPtr + k) % N;
                if (r[c]) begin
                    mOwner = c;
                    mActive = 1;
                    mAge = 1;
                    break;
                end
            end
        end
    endtask

    task automatic randomPhase(input int cycles);
        logic [N-1:0]   reqs;
        logic [W-1:0]   dat [N];
        int             cd  [N];
        logic [N*W-1:0] flat;
        reqs = '0;
        for (int i = 0; i < N; i++) begin
            dat[i] = '0;
            cd[i] = -1;
        end
        doReset();
        modelReset();
        for (int t = 0; t < cycles; t++) begin
            for (int i = 0; i < N; i++) begin
                if (bus.wr_done && bus.gnt[i]) cd[i] = $urandom_range(0, 2);
                if (cd[i] == 0) begin
                    reqs[i] = 1'b0;
                    cd[i] = -1;
                end else if (cd[i] > 0) begin
                    cd[i]--;
                end else if (!reqs[i] && $urandom_range(0, 3) == 0) begin
                    reqs[i] = 1'b1;
                    dat[i] = W'($urandom_range(0, 15));
                end
            end
            for (int i = 0; i < N; i++) flat[i*W +: W] = dat[i];
            applyStimulus(reqs, flat);
            tick();
            modelStep(reqs, flat);
            checkOutput("rnd_gnt", 32'(bus.gnt), mActive ? 32'(1 << mOwner) : 32'd0);
            checkOutput("rnd_owner", 32'(bus.owner), 32'(mOwner));
            checkOutput("rnd_y", 32'(bus.y), 32'(mY));
            checkOutput("rnd_yvalid", 32'(bus.y_valid), 32'(mValid));
            checkOutput("rnd_wrdone", 32'(bus.wr_done), 32'(mWrDone));
            checkOutput("rnd_busy", 32'(bus.busy), 32'(mActive));
`ifdef REG_WRITE_ARBITER_TIMEOUT_EN
            checkOutput("rnd_timeout", 32'(bus.timeout_err), 32'd0);
`endif
        end
        bus.req = '0;
        repeat (5) tick();
    endtask

    initial begin
        vecs[0] = '{4'b0100, 16'h0A00, 1'b0, 2, 4'hA};
        vecs[1] = '{4'b1000, 16'h5000, 1'b0, 3, 4'h5};
        vecs[2] = '{4'b1001, 16'h7003, 1'b0, 0, 4'h3};
        vecs[3] = '{4'b1001, 16'h7003, 1'b0, 3, 4'h7};
        vecs[4] = '{4'b0011, 16'h00E1, 1'b0, 0, 4'h1};
        vecs[5] = '{4'b0011, 16'h00E1, 1'b0, 1, 4'hE};
        vecs[6] = '{4'b1111, 16'h4321, 1'b0, 2, 4'h3};
        vecs[7] = '{4'b0010, 16'h00F0, 1'b1, 1, 4'hF};

        applyStimulus('0, '0);
        repeat (2) tick();
        reset = 1'b0;
        checkOutput("rst_gnt", 32'(bus.gnt), 32'd0);
        checkOutput("rst_owner", 32'(bus.owner), 32'd0);
        checkOutput("rst_y", 32'(bus.y), 32'd0);
        checkOutput("rst_yvalid", 32'(bus.y_valid), 32'd0);
        checkOutput("rst_wrdone", 32'(bus.wr_done), 32'd0);
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);

        for (int i = 0; i < 8; i++) runVector(vecs[i], i);

        $display("[TB] reset during RELEASE");
        applyStimulus(4'b0010, 16'h00B0);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        checkOutput("midrst_gnt", 32'(bus.gnt), 32'd0);
        checkOutput("midrst_y", 32'(bus.y), 32'd0);
        checkOutput("midrst_yvalid", 32'(bus.y_valid), 32'd0);
        checkOutput("midrst_busy", 32'(bus.busy), 32'd0);
        checkOutput("midrst_owner", 32'(bus.owner), 32'd0);
        reset = 1'b0;
        bus.req = '0;
        tick();

        $display("[TB] all requesters continuously");
        serveAndLog(4'b1111, 16'h4321, 1'b1, 5);
        checkLogs("all4", '{0, 1, 2, 3, 0}, '{1, 2, 3, 4, 1});

        $display("[TB] wrap and fairness");
        doReset();
        runVector('{4'b1000, 16'h9000, 1'b0, 3, 4'h9}, 100);
        serveAndLog(4'b1001, 16'h6005, 1'b0, 2);
        checkLogs("wrap", '{0, 3}, '{5, 6});

`ifdef REG_WRITE_ARBITER_TIMEOUT_EN
        $display("[TB] release timeout");
        doReset();
        applyStimulus(4'b0011, 16'h0021);
        tick();
        checkOutput("to_gnt0", 32'(bus.gnt), 32'b0001);
        tick();
        checkOutput("to_wrdone", 32'(bus.wr_done), 32'd1);
        repeat (7) tick();
        checkOutput("to_still_held", 32'(bus.gnt), 32'b0001);
        checkOutput("to_err_early", 32'(bus.timeout_err), 32'd0);
        tick();
        checkOutput("to_err", 32'(bus.timeout_err), 32'd1);
        checkOutput("to_gnt_off", 32'(bus.gnt), 32'd0);
        tick();
        checkOutput("to_next_gnt", 32'(bus.gnt), 32'b0010);
        checkOutput("to_err_pulse", 32'(bus.timeout_err), 32'd0);
        bus.req = '0;
        repeat (5) tick();
`endif

        $display("[TB] randomized traffic");
        randomPhase(400);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
